// File: rtl/tt_um_jimktrains_vslc_prefetch.sv
// Instruction prefetch between the SPI EEPROM byte reader and the executor.
// Optional same-cycle bypass of an empty FIFO: define VSLC_PREFETCH_PASSTHRU_EN.
module tt_um_jimktrains_vslc_prefetch #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       byte_valid,
    input  logic [7:0]                 byte_data,
    input  logic [15:0]                byte_addr,
    output logic                       instr_valid,
    output logic [7:0]                 instr_data,
    output logic                       instr_last,
    input  logic                       instr_ready,
    output logic [ADDR_W-1:0]          start_addr,
    output logic [ADDR_W-1:0]          end_addr,
    output logic                       hdr_done,
    output logic                       restart_req,
    output logic                       hold_n,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int LW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {HDR, RUN, DRAIN, RESYNC} state_t;
    state_t state, state_n;

    logic [8:0]    mem [DEPTH];
    logic [LW-1:0] wr_ptr, rd_ptr, cnt, level_n;
    logic [7:0]    data_q;
    logic [8:0]    head;
    logic [15:0]   ext_start, ext_end;
    logic          fifo_empty, fifo_full, byte_last;
    logic          push_req, push, pop, bypass, drop_ovf, restart_n, hold_next;

    assign cnt        = wr_ptr - rd_ptr;
    assign fifo_empty = (cnt == '0);
    assign fifo_full  = (cnt == LW'(DEPTH));
    assign head       = mem[rd_ptr[LW-2:0]];
    assign ext_start  = {{(16-ADDR_W){1'b0}}, start_addr};
    assign ext_end    = {{(16-ADDR_W){1'b0}}, end_addr};
    assign byte_last  = (end_addr != '0) && (byte_addr >= ext_end);

    // A byte the stage wants to keep: program bytes in RUN, or the restart byte in RESYNC.
    assign push_req = byte_valid &&
                      ((state == RUN    && byte_addr > 16'd3) ||
                       (state == RESYNC && byte_addr == ext_start));
    assign pop      = !fifo_empty && instr_ready;

`ifdef VSLC_PREFETCH_PASSTHRU_EN
    assign bypass      = push_req && fifo_empty && instr_ready;
    assign instr_valid = !fifo_empty || bypass;
    assign instr_data  = !fifo_empty ? head[7:0] : (bypass ? byte_data : data_q);
    assign instr_last  = !fifo_empty ? head[8] : (bypass && byte_last);
`else
    assign bypass      = 1'b0;
    assign instr_valid = !fifo_empty;
    assign instr_data  = fifo_empty ? data_q : head[7:0];
    assign instr_last  = !fifo_empty && head[8];
`endif

    assign push     = push_req && !bypass && (!fifo_full || pop);
    assign drop_ovf = push_req && !bypass && fifo_full && !pop;
    assign level_n  = cnt + LW'(push) - LW'(pop);
    assign level    = cnt;

    always_comb begin
        state_n   = state;
        restart_n = 1'b0;
        case (state)
            HDR:    if (byte_valid && byte_addr == 16'd3) state_n = RUN;
            RUN, RESYNC: begin
                if (push && byte_last)        state_n = DRAIN;
                else if (bypass && byte_last) begin
                    state_n   = RESYNC;
                    restart_n = 1'b1;
                end else if (push || bypass)  state_n = RUN;
            end
            DRAIN: if (pop && head[8]) begin
                state_n   = RESYNC;
                restart_n = 1'b1;
            end
            default: state_n = HDR;
        endcase
    end

    // Keep the reader streaming while it runs out to its restart point.
    assign hold_next = (state_n == DRAIN) || (state_n == RESYNC) ||
                       (level_n < LW'(DEPTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= HDR;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            data_q      <= '0;
            start_addr  <= '0;
            end_addr    <= '0;
            hdr_done    <= 1'b0;
            restart_req <= 1'b0;
            hold_n      <= 1'b1;
            overflow    <= 1'b0;
        end else begin
            state       <= state_n;
            restart_req <= restart_n;
            hold_n      <= hold_next;
            if (push)     wr_ptr   <= wr_ptr + 1'b1;
            if (pop)      rd_ptr   <= rd_ptr + 1'b1;
            if (drop_ovf) overflow <= 1'b1;
            if (pop)         data_q <= head[7:0];
            else if (bypass) data_q <= byte_data;
            if (state == HDR && byte_valid) begin
                case (byte_addr)
                    16'd0: start_addr[ADDR_W-1:8] <= byte_data[ADDR_W-9:0];
                    16'd1: start_addr[7:0]        <= byte_data;
                    16'd2: end_addr[ADDR_W-1:8]   <= byte_data[ADDR_W-9:0];
                    16'd3: begin
                        end_addr[7:0] <= byte_data;
                        hdr_done      <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[LW-2:0]] <= {byte_last, byte_data};
    end
endmodule

// File: tb/tb_tt_um_jimktrains_vslc_prefetch.sv
// Directed bench for the prefetch stage; popped bytes are checked against a scoreboard queue.
module tb_tt_um_jimktrains_vslc_prefetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic [15:0] byte_addr = '0;
    logic        instr_ready = 1'b0;
    logic        instr_valid, instr_last, hdr_done, restart_req, hold_n, overflow;
    logic [7:0]  instr_data;
    logic [9:0]  start_addr, end_addr;
    logic [2:0]  level;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    logic [8:0] sb[$];

    tt_um_jimktrains_vslc_prefetch #(.DEPTH(4), .ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_addr(byte_addr), .instr_valid(instr_valid), .instr_data(instr_data),
        .instr_last(instr_last), .instr_ready(instr_ready), .start_addr(start_addr),
        .end_addr(end_addr), .hdr_done(hdr_done), .restart_req(restart_req),
        .hold_n(hold_n), .overflow(overflow), .level(level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One byte from the reader; when keep is set the bench expects it to reach the executor.
    task automatic send(input logic [15:0] a, input logic [7:0] d, input bit keep, input bit lst);
        if (keep) sb.push_back({lst, d});
        byte_valid = 1'b1;
        byte_addr  = a;
        byte_data  = d;
        cyc();
        byte_valid = 1'b0;
    endtask

    // Handshakes are sampled mid-cycle, away from the edge that performs the pop.
    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready) begin
            if (sb.size() == 0) chk("sb_unexpected_pop", {23'd0, instr_last, instr_data}, 32'hDEADBEEF);
            else chk("sb_head", {23'd0, instr_last, instr_data}, {23'd0, sb.pop_front()});
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        cyc(); cyc();
        chk("rst_valid", instr_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_hold_n", hold_n, 1);
        chk("rst_hdr_done", hdr_done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_restart", restart_req, 0);
        chk("rst_data", instr_data, 0);
        rst = 1'b0;
        cyc();

        // T1 header capture
        send(16'd0, 8'h01, 0, 0);
        send(16'd1, 8'h20, 0, 0);
        send(16'd2, 8'h01, 0, 0);
        chk("t1_hdr_not_yet", hdr_done, 0);
        send(16'd3, 8'h30, 0, 0);
        chk("t1_start", start_addr, 10'h120);
        chk("t1_end", end_addr, 10'h130);
        chk("t1_hdr_done", hdr_done, 1);

        // Fresh header: start=0x004, end=0x006
        rst = 1'b1; cyc(); rst = 1'b0;
        send(16'd0, 8'h00, 0, 0);
        send(16'd1, 8'h04, 0, 0);
        send(16'd2, 8'h00, 0, 0);
        send(16'd3, 8'h06, 0, 0);
        chk("t2_start", start_addr, 10'h004);
        chk("t2_end", end_addr, 10'h006);

        // T2 stream to end-of-scan with the executor always ready
        instr_ready = 1'b1;
        send(16'd4, 8'hAA, 1, 0);
        send(16'd5, 8'hBB, 1, 0);
        chk("t2_bb_last", instr_last, 0);
        send(16'd6, 8'hCC, 1, 1);
        chk("t2_cc_data", instr_data, 8'hCC);
        chk("t2_cc_last", instr_last, 1);
        chk("t2_no_restart_yet", restart_req, 0);
        send(16'd7, 8'hDD, 0, 0);
        chk("t2_restart", restart_req, 1);
        chk("t2_level0", level, 0);
        chk("t2_valid0", instr_valid, 0);
        chk("t2_data_hold", instr_data, 8'hCC);
        cyc();
        chk("t2_restart_pulse", restart_req, 0);

        // T5 resync: wrong address dropped, start address pushed
        instr_ready = 1'b0;
        send(16'h000A, 8'h11, 0, 0);
        chk("t5_drop", level, 0);
        send(16'h0004, 8'h44, 1, 0);
        chk("t5_push", level, 1);
        chk("t5_valid", instr_valid, 1);

        // T3 backpressure
        send(16'd5, 8'h55, 1, 0);
        chk("t3_l2", level, 2);
        chk("t3_hold_l2", hold_n, 1);
        send(16'd4, 8'h66, 1, 0);
        chk("t3_l3", level, 3);
        chk("t3_hold_l3", hold_n, 0);
        send(16'd5, 8'h77, 1, 0);
        chk("t3_l4", level, 4);
        chk("t3_hold_l4", hold_n, 0);

        // T4 full with simultaneous push and pop
        instr_ready = 1'b1;
        send(16'd4, 8'h99, 1, 0);
        instr_ready = 1'b0;
        chk("t4_level", level, 4);
        chk("t4_no_ovf", overflow, 0);

        // Full and no pop: byte dropped
        send(16'd5, 8'h88, 0, 0);
        chk("t3_ovf", overflow, 1);
        chk("t3_ovf_level", level, 4);
        instr_ready = 1'b1;
        repeat (4) cyc();
        instr_ready = 1'b0;
        chk("t3_drained", level, 0);
        chk("t3_sb_empty", sb.size(), 0);
        chk("t3_ovf_sticky", overflow, 1);

        // T6 reset mid-DRAIN with two entries pending
        send(16'd4, 8'hA1, 0, 0);
        send(16'd6, 8'hA2, 0, 0);
        chk("t6_level2", level, 2);
        chk("t6_hold_drain", hold_n, 1);
        rst = 1'b1;
        #1;
        chk("t6_valid", instr_valid, 0);
        chk("t6_level", level, 0);
        chk("t6_hdr_done", hdr_done, 0);
        chk("t6_hold_n", hold_n, 1);
        chk("t6_overflow", overflow, 0);
        cyc();
        rst = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
